// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci request scheduler: FSM state, round-robin reset value, response record.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Pointer holds the next requester to be given priority; 0 means requester 0 goes first.
    localparam int RR_PTR_RESET = 0;

    // Response record widths track the scheduler's default DATA_WIDTH / ID_WIDTH.
    localparam int RSP_DATA_W = 32;
    localparam int RSP_ID_W   = 2;

    typedef struct packed {
        logic [RSP_ID_W-1:0]   id;
        logic [RSP_DATA_W-1:0] data;
        logic                  ovf;
    } rsp_t;

endpackage

// File: rtl/fib_core.sv
// Restartable Fibonacci stepper: holds cur=F(k), prev=F(k-1) and advances one term per step.
module fib_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  restart,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] cur,
    output logic                  carry
);

    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] r_cur;
    logic [DATA_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_cur} + {1'b0, r_prev};
    assign carry = w_sum[DATA_WIDTH];
    assign cur   = r_cur;

    // prev=0, cur=1 makes the first step yield F1=1 from F0=1.
    always_ff @(posedge clk) begin
        if (!resetn || restart) begin
            r_prev <= '0;
            r_cur  <= DATA_WIDTH'(1);
        end else if (step) begin
            r_prev <= r_cur;
            r_cur  <= w_sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fib_req_scheduler.sv
// Round-robin scheduler sharing one Fibonacci core between NUM_REQ requesters.
//   state | meaning
//   IDLE  | arbitrate pending requests; grant handshake restarts the core
//   RUN   | step core until cnt == idx
//   RESP  | hold response until rsp_ready
module fib_req_scheduler
    import fib_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 6,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*IDX_WIDTH-1:0]   req_idx,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_ovf,
    output logic                           busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [ID_WIDTH-1:0]   r_id;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [IDX_WIDTH-1:0]  r_cnt;
    logic                  r_ovf;
    logic                  r_rsp_valid;
    rsp_t                  r_rsp;

    logic [ID_WIDTH-1:0]   w_gnt_id;
    logic [IDX_WIDTH-1:0]  w_gnt_idx;
    logic                  w_hs;
    logic                  w_done;
    logic                  w_restart;
    logic                  w_step;
    logic [DATA_WIDTH-1:0] w_cur;
    logic                  w_carry;

    // Lowest offset from ptr wins, so scan from the far end and let nearer hits overwrite.
    function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                    input logic [ID_WIDTH-1:0] ptr);
        int                  k;
        logic [ID_WIDTH-1:0] kk;
        rr_pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            kk = ID_WIDTH'(k);
            if (valid[kk]) rr_pick = kk;
        end
    endfunction

    assign w_gnt_id = rr_pick(req_valid, r_ptr);
    assign w_hs     = resetn && (r_state == IDLE) && (|req_valid);
    assign w_done   = (r_state == RUN) && (r_cnt == r_idx);

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_gnt_id == ID_WIDTH'(i)) w_gnt_idx = req_idx[i*IDX_WIDTH +: IDX_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs)      w_state_nxt = RUN;
            RUN:     if (w_done)    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_hs) req_ready[w_gnt_id] = 1'b1;
        busy      = (r_state != IDLE);
        w_restart = w_hs;
        w_step    = (r_state == RUN) && !w_done;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr       <= ID_WIDTH'(RR_PTR_RESET);
            r_id        <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_hs) begin
                r_idx <= w_gnt_idx;
                r_id  <= w_gnt_id;
                r_ptr <= (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_WIDTH'(1);
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
            if (w_step) begin
                r_cnt <= r_cnt + IDX_WIDTH'(1);
                r_ovf <= r_ovf | w_carry;
            end
            if (w_done) begin
                r_rsp.id    <= RSP_ID_W'(r_id);
                r_rsp.data  <= RSP_DATA_W'(w_cur);
                r_rsp.ovf   <= r_ovf;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == RESP) && rsp_ready) r_rsp_valid <= 1'b0;
        end
    end

    fib_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .clk    (clk),
        .resetn (resetn),
        .restart(w_restart),
        .step   (w_step),
        .cur    (w_cur),
        .carry  (w_carry)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = ID_WIDTH'(r_rsp.id);
    assign rsp_data  = DATA_WIDTH'(r_rsp.data);
    assign rsp_ovf   = r_rsp.ovf;

endmodule

// File: tb/tb_fib_req_scheduler.sv
// Scoreboard bench for fib_req_scheduler: grants, latency, response values, hold and reset behaviour.
module tb_fib_req_scheduler;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int IW  = 6;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*IW-1:0]  req_idx = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_ovf;
    logic              busy;

    fib_req_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_idx(req_idx),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Exact 64-bit Fibonacci; overflow iff the true term no longer fits in DW bits.
    function automatic void fib_model(input int n, output logic [DW-1:0] f, output logic o);
        longint unsigned a, b, t;
        a = 1; b = 1;
        for (int i = 1; i < n; i++) begin
            t = a + b; a = b; b = t;
        end
        t = (n == 0) ? a : b;
        f = t[DW-1:0];
        o = (t >= (64'd1 << DW));
    endfunction

    typedef struct {
        int         id;
        int         idx;
        int         hs;
        logic [DW-1:0] data;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    int             ptr_m = 0;
    bit             busy_m = 0;
    bit             pv_valid = 0, pv_ready = 0, pv_resetn = 0;
    logic [DW-1:0]  pv_data = '0;
    logic [IDW-1:0] pv_id = '0;
    logic           pv_ovf = 1'b0;

    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy;
        int            g;
        exp_t          e;
        if (!resetn) begin
            check_eq("rst_req_ready", req_ready, 0);
            sb.delete();
            ptr_m    = 0;
            busy_m   = 0;
            pv_valid = 0;
            pv_ready = 0;
        end else begin
            if (!pv_resetn) check_eq("post_rst_rsp_valid", rsp_valid, 0);
            check_eq("busy", busy, busy_m);
            exp_rdy = '0;
            g = -1;
            if (!busy_m)
                for (int i = NR - 1; i >= 0; i--)
                    if (req_valid[(ptr_m + i) % NR]) g = (ptr_m + i) % NR;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check_eq("req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                e.id  = g;
                e.idx = int'(req_idx[g*IW +: IW]);
                e.hs  = cyc;
                fib_model(e.idx, e.data, e.ovf);
                sb.push_back(e);
                ptr_m  = (g + 1) % NR;
                busy_m = 1;
            end
            if (rsp_valid && !pv_valid) begin
                if (sb.size() == 0) check_eq("rsp_unexpected", rsp_valid, 0);
                else check_eq("latency", cyc - sb[0].hs, sb[0].idx + 2);
            end
            if (rsp_valid && pv_valid && !pv_ready) begin
                check_eq("hold_data", rsp_data, pv_data);
                check_eq("hold_id", rsp_id, pv_id);
                check_eq("hold_ovf", rsp_ovf, pv_ovf);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) check_eq("rsp_no_expect", rsp_valid, 0);
                else begin
                    e = sb.pop_front();
                    check_eq("rsp_id", rsp_id, e.id);
                    check_eq("rsp_data", rsp_data, e.data);
                    check_eq("rsp_ovf", rsp_ovf, e.ovf);
                end
                busy_m = 0;
            end
            pv_valid = rsp_valid;
            pv_ready = rsp_ready;
            pv_data  = rsp_data;
            pv_id    = rsp_id;
            pv_ovf   = rsp_ovf;
        end
        pv_resetn = resetn;
    end

    task automatic request(input int r, input int idx);
        bit got = 0;
        @(posedge clk); #1;
        req_idx[r*IW +: IW] = IW'(idx);
        req_valid[r] = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1;
        end
        check_eq("req_granted", got, 1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && req_valid == '0) done = 1;
        end
        check_eq("idle_reached", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  grants;
        bit  seen;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_ovf", rsp_ovf, 0);
        check_eq("rst_busy", busy, 0);

        // all requesters valid: rotation starting from requester 0
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) req_idx[i*IW +: IW] = IW'(3);
        req_valid = '1;
        grants = 0;
        for (int c = 0; c < 200 && grants < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check_eq("rr_order", req_ready, 4'b0001 << (grants % NR));
                grants++;
            end
        end
        check_eq("rr_grants", grants, 5);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        request(2, 5);
        wait_idle();

        request(0, 0);
        request(0, 1);
        wait_idle();

        request(3, 46);
        request(3, 47);
        wait_idle();

        // response held under backpressure; requester 0 drops out before being served
        rsp_ready = 1'b0;
        request(3, 4);
        req_idx[0*IW +: IW] = IW'(2);
        req_idx[2*IW +: IW] = IW'(7);
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check_eq("rsp_seen", seen, 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("resp_done", rsp_valid, 0);
        check_eq("skip_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_idle();

        // reset at cnt=7 of an idx=20 job
        request(0, 20);
        repeat (7) @(posedge clk);
        #1 resetn = 1'b0;
        req_idx[0*IW +: IW] = IW'(9);
        req_idx[1*IW +: IW] = IW'(2);
        req_valid = 4'b0011;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[1]) seen = 1;
        end
        check_eq("second_grant", seen, 1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_idle();

        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_req_scheduler.md
Name: fib_req_scheduler

Overview:
- Shares one Fibonacci datapath between NUM_REQ requesters.
- Each requester asks for the index N of a term and receives F(N), where F0=1, F1=1 and Fn = Fn-1 + Fn-2.
- Grants requests round-robin, restarts and steps the shared core exactly N times, then returns the result over a valid/ready response port.
- Sits between client blocks and the Fibonacci core.

Parameters:
- NUM_REQ, 4: number of requesters (at least 2).
- DATA_WIDTH, 32: width of Fibonacci values.
- IDX_WIDTH, 6: width of the requested index N.
- ID_WIDTH, $clog2(NUM_REQ): width of the requester id.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_idx  in  NUM_REQ*IDX_WIDTH  packed requested indices; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted by consumer.
- rsp_id  out  ID_WIDTH  requester that owns the response.
- rsp_data  out  DATA_WIDTH  F(N) modulo 2^DATA_WIDTH.
- rsp_ovf  out  1  at least one addition carried out of DATA_WIDTH during this computation.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset:
  - Reset is clk and resetn, synchronous, active-low.
  - Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, busy=0.
  - Round-robin pointer resets so requester 0 has highest priority.
  - req_ready is forced to 0 while resetn is low.
  - Reset mid-operation abandons the job. No response is produced and the core state is discarded.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid is set, grant exactly one requester: the first valid at or after (last_grant+1) mod NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle; that cycle is the handshake.
  - On the handshake edge: latch idx=req_idx[g] and id=g, set last_grant=g, clear cnt and ovf, assert core restart, go to RUN.
  - req_ready is 0 in all other states.
- RUN:
  - Core holds cur=F(cnt).
  - If cnt != idx: step the core, cnt<=cnt+1, ovf<=ovf|carry.
  - If cnt == idx: rsp_data<=cur, rsp_id<=id, rsp_ovf<=ovf, rsp_valid<=1, go to RESP.
- RESP:
  - Hold rsp_valid and the response data stable until rsp_ready=1.
  - On that edge: rsp_valid<=0, go to IDLE.
  - The next grant happens no earlier than the following cycle.
- Latency: handshake at cycle t gives rsp_valid first high at t+idx+2.
  - idx=0 gives t+2.
  - idx=2^IDX_WIDTH-1 is legal and needs no special case.
- Arithmetic:
  - Additions wrap modulo 2^DATA_WIDTH.
  - carry is the carry-out of the step addition.
  - With DATA_WIDTH=32: F46=2971215073 has rsp_ovf=0; F47 wraps to 512559680 with rsp_ovf=1.
- Requests arriving while busy are not accepted; the requester keeps req_valid asserted.
- A requester that drops req_valid before its grant is skipped.
- Fairness: with all requesters permanently valid, grants rotate 0,1,...,NUM_REQ-1,0.
- rsp_ready high while rsp_valid is low is ignored.

Decomposition:
- Package fib_pkg:
  - state enum typedef (IDLE, RUN, RESP).
  - Localparam for the reset pointer value.
  - Response struct typedef {id, data, ovf}.
- Sub-module fib_core (params DATA_WIDTH):
  - Ports: clk, resetn, restart, step, cur, carry.
  - Registers prev/cur.
  - restart or reset sets prev=0, cur=1.
  - step sets prev<=cur, cur<=cur+prev.
  - carry is combinational from cur+prev.
  - restart has priority over step.
- Round-robin arbiter: inline function, no separate module.

Test Plan:
1. Reset, then requester 2 sends idx=5 with rsp_ready=1 → req_ready=4'b0100 in the handshake cycle; rsp_valid at t+7 with rsp_data=8, rsp_id=2, rsp_ovf=0.
2. idx=0 and idx=1 back-to-back from requester 0 → rsp_data=1 at t+2, then 1 at the second handshake+3.
3. All four requesters valid with idx=3, rsp_ready=1 → grant order 0,1,2,3,0; every rsp_data=3; no grant while busy.
4. DATA_WIDTH=32, idx=46 then idx=47 → 2971215073 with ovf=0, then 512559680 with ovf=1.
5. rsp_ready held low for 10 cycles in RESP → rsp_valid, rsp_data and rsp_id stable; no new req_ready; completes the cycle after rsp_ready=1.
6. resetn low for one cycle mid-RUN (idx=20, cnt=7) → next cycle rsp_valid=0, busy=0, req_ready=0 during reset; next grant goes to requester 0 and returns F(idx) correctly.
